result_fifo: RTL and testbench
==============================

// Module: result_fifo
// PURPOSE
//   Output buffer directly downstream of the series-evaluation engine (top). The engine emits a
//   one-cycle result_valid pulse with its result, overflow and error flags and cannot be stalled.
//   This block captures each result into a small FIFO and presents it on a valid/ready interface.
//   It counts and flags results lost to a full buffer.
// PARAMETERS
//   RES_SIZE  32  result width; must equal the engine's RES_SIZE
//   DEPTH     4   FIFO entries, power of two, >= 2
//   PTR_SIZE  2   log2(DEPTH)
//   DROP_SIZE 8   width of the dropped-result counter
// PORTS
//   clk          in   1            system clock, rising edge
//   rst          in   1            synchronous reset, active-high
//   flush        in   1            synchronous discard of all entries
//   res_i        in   RES_SIZE     engine result
//   res_valid_i  in   1            one-cycle pulse: res_i and the flags are valid
//   res_ovf_i    in   1            engine overflow flag
//   res_err_i    in   1            engine error flag
//   out_data     out  RES_SIZE     head-entry data
//   out_ovf      out  1            head-entry overflow flag
//   out_err      out  1            head-entry error flag
//   out_valid    out  1            head entry available
//   out_ready_i  in   1            consumer accepts the head entry
//   full         out  1            count == DEPTH
//   empty        out  1            count == 0
//   count        out  PTR_SIZE+1   entries held
//   drop_cnt     out  DROP_SIZE    results lost; saturates at all-ones
//   drop_flag    out  1            sticky: at least one result lost since reset/flush
// BEHAVIOUR
//   - Entry = {err, ovf, data}, RES_SIZE+2 bits. Pointers wrap modulo DEPTH.
//   - Reset (rst=1 at clk edge): pointers=0, count=0, empty=1, full=0, out_valid=0, out_data=0,
//     out_ovf=0, out_err=0, drop_cnt=0, drop_flag=0. Mid-operation reset discards all contents
//     and any push or pop in the same cycle.
//   - flush: same effect as reset on pointers, count, drop_cnt and drop_flag. Priority is
//     rst > flush > push/pop. A push coinciding with flush is discarded.
//   - push = res_valid_i. pop = out_valid & out_ready_i.
//   - Error entries: when res_err_i=1, stored data is forced to 0. The err and ovf bits are
//     stored as received.
//   - Latency: a push into an empty FIFO drives out_valid=1 on the next cycle. There is no
//     combinational input-to-output path.
//   - Head is stable: out_data, out_ovf and out_err do not change while out_valid & !out_ready_i.
//   - Full and push with pop: both are performed; count is unchanged.
//   - Full and push without pop: the result is dropped, drop_cnt+1 (saturating), drop_flag<=1,
//     and contents are unchanged.
//   - Empty and pop: impossible, because out_valid=0. out_ready_i is ignored.
//   - Push and pop when not full and not empty: count is unchanged and the order is preserved.
//   - full, empty and count are registered and consistent in the same cycle.
// CONFIGURATION
//   RESULT_SAT_EN defined: a push with res_ovf_i=1 and res_err_i=0 stores data={RES_SIZE{1'b1}}
//     (saturated); the ovf bit is still stored as 1.
//   RESULT_SAT_EN undefined: overflow entries store the raw res_i.
//   The error-forces-zero rule applies in both builds.
// STRUCTURE
//   - Shared package (series_pkg): RES_SIZE/IN_SIZE/ACC_SIZE default constants shared with top;
//     typedef res_entry_t {err, ovf, data}; DROP_SIZE default.
//   - Sub-module fifo_mem: DEPTH x (RES_SIZE+2) register array with one write port and one
//     registered read port, no reset on the storage array.
//   - This module holds the pointers, count, flags, drop logic and saturation mux.
// TESTING
//   1 rst; push res_i=32'h0000_0123 with out_ready_i=1 -> next cycle out_valid=1,
//     out_data=32'h123; following cycle empty=1.
//   2 out_ready_i=0; push 5 results (DEPTH=4) -> full=1, count=4, drop_cnt=1, drop_flag=1;
//     drain -> the first 4 values come out in order.
//   3 full; same-cycle push 32'hAA and pop with out_ready_i=1 -> count stays 4; 32'hAA
//     appears last.
//   4 push res_err_i=1, res_i=32'hDEAD -> out_data=0, out_err=1. Push res_ovf_i=1,
//     res_i=32'h5 -> out_data=32'hFFFF_FFFF with RESULT_SAT_EN, 32'h5 without; out_ovf=1
//     in both builds.
//   5 3 entries held, then assert flush together with a push -> next cycle count=0, empty=1,
//     out_valid=0, drop_cnt=0.
//   6 force 260 drops with DROP_SIZE=8 -> drop_cnt holds 8'hFF. Assert rst mid-drain ->
//     all outputs return to their reset values.

Source files
------------

// File: rtl/series_pkg.sv
// Constants and types shared by the series-evaluation engine and its result buffer.
// The result entry layout {err, ovf, data} is fixed here so producer and consumer agree.
package series_pkg;

  localparam int RES_SIZE       = 32;
  localparam int IN_SIZE        = 16;
  localparam int ACC_SIZE       = 48;
  localparam int DROP_SIZE_DEF  = 8;
  localparam int DEPTH_DEF      = 4;
  localparam int PTR_SIZE_DEF   = 2;

  typedef struct packed {
    logic                err;
    logic                ovf;
    logic [RES_SIZE-1:0] data;
  } res_entry_t;

endpackage

// File: rtl/fifo_mem.sv
// Storage for result_fifo: DEPTH x W register array, one write port, one registered read port.
// A same-cycle write to the address being read is forwarded so a new head appears one cycle later.
module fifo_mem #(
  parameter int W        = 34,
  parameter int DEPTH    = 4,
  parameter int PTR_SIZE = 2
) (
  input  logic                clk,
  input  logic                clr_i,
  input  logic                wr_en_i,
  input  logic [PTR_SIZE-1:0] wr_addr_i,
  input  logic [W-1:0]        wr_data_i,
  input  logic                rd_en_i,
  input  logic [PTR_SIZE-1:0] rd_addr_i,
  output logic [W-1:0]        rd_data_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rd_data_q;

  // NOTE: the storage array has no reset; validity is tracked by the pointers and count,
  // so clearing it would only cost a reset net on every bit.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // NOTE: sequential state is always assigned with <= so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= (wr_en_i && (wr_addr_i == rd_addr_i)) ? wr_data_i : mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/result_fifo.sv
// Result buffer behind the series engine: captures unstallable result pulses, serves valid/ready.
// Build option RESULT_SAT_EN: overflow (non-error) results are stored saturated to all-ones.
module result_fifo
  import series_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int PTR_SIZE  = PTR_SIZE_DEF,
  parameter int DROP_SIZE = DROP_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [RES_SIZE-1:0]  res_i,
  input  logic                 res_valid_i,
  input  logic                 res_ovf_i,
  input  logic                 res_err_i,
  output logic [RES_SIZE-1:0]  out_data,
  output logic                 out_ovf,
  output logic                 out_err,
  output logic                 out_valid,
  input  logic                 out_ready_i,
  output logic                 full,
  output logic                 empty,
  output logic [PTR_SIZE:0]    count,
  output logic [DROP_SIZE-1:0] drop_cnt,
  output logic                 drop_flag
);

  localparam logic [PTR_SIZE:0]    CNT_FULL = (PTR_SIZE+1)'(DEPTH);
  localparam logic [PTR_SIZE:0]    CNT_ONE  = (PTR_SIZE+1)'(1);
  localparam logic [PTR_SIZE-1:0]  PTR_ONE  = PTR_SIZE'(1);
  localparam logic [DROP_SIZE-1:0] DROP_ONE = DROP_SIZE'(1);

  logic [PTR_SIZE-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_SIZE:0]    count_q, count_d;
  logic                 full_q, full_d, empty_q, empty_d;
  logic [DROP_SIZE-1:0] drop_cnt_q, drop_cnt_d;
  logic                 drop_flag_q, drop_flag_d;

  logic       push, pop, do_write, do_drop;
  res_entry_t wr_entry, rd_entry;

  always_comb begin
    wr_entry.err  = res_err_i;
    wr_entry.ovf  = res_ovf_i;
    wr_entry.data = res_i;
    if (res_err_i) begin
      wr_entry.data = '0;
    end
`ifdef RESULT_SAT_EN
    else if (res_ovf_i) begin
      wr_entry.data = '1;
    end
`endif
  end

  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign push     = res_valid_i;
  assign pop      = ~empty_q & out_ready_i;
  assign do_write = push & (~full_q | pop);
  assign do_drop  = push & full_q & ~pop;

  // NOTE: every variable gets its default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    drop_cnt_d  = drop_cnt_q;
    drop_flag_d = drop_flag_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      drop_cnt_d  = '0;
      drop_flag_d = 1'b0;
    end else begin
      if (do_write) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)      rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({do_write, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      if (do_drop) begin
        drop_flag_d = 1'b1;
        if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_ONE;
      end
    end
    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      drop_cnt_q  <= '0;
      drop_flag_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      drop_cnt_q  <= drop_cnt_d;
      drop_flag_q <= drop_flag_d;
    end
  end

  // The read port prefetches the next head (rd_ptr_d) so the output register always holds it.
  fifo_mem #(
    .W        ($bits(res_entry_t)),
    .DEPTH    (DEPTH),
    .PTR_SIZE (PTR_SIZE)
  ) u_mem (
    .clk       (clk),
    .clr_i     (rst | flush),
    .wr_en_i   (do_write & ~flush & ~rst),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_entry),
    .rd_en_i   (count_d != '0),
    .rd_addr_i (rd_ptr_d),
    .rd_data_o (rd_entry)
  );

  assign out_data  = rd_entry.data;
  assign out_ovf   = rd_entry.ovf;
  assign out_err   = rd_entry.err;
  assign out_valid = ~empty_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;
  assign drop_cnt  = drop_cnt_q;
  assign drop_flag = drop_flag_q;

endmodule

// File: tb/tb_result_fifo.sv
// Self-checking bench for result_fifo: directed scenarios plus random traffic against a queue model.
// A negedge monitor checks every popped head against the scoreboard queue.
module tb_result_fifo;
  import series_pkg::*;

  localparam int DEPTH = 4;
`ifdef RESULT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst, flush, res_valid_i, res_ovf_i, res_err_i, out_ready_i;
  logic [RES_SIZE-1:0] res_i, out_data;
  logic                out_ovf, out_err, out_valid, full, empty, drop_flag;
  logic [2:0]          count;
  logic [7:0]          drop_cnt;

  int errors = 0;
  int checks = 0;

  res_entry_t sb[$];
  int         m_count = 0;
  int         m_drop  = 0;
  bit         m_flag  = 1'b0;

  always #5 clk = ~clk;

  result_fifo dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .res_i       (res_i),
    .res_valid_i (res_valid_i),
    .res_ovf_i   (res_ovf_i),
    .res_err_i   (res_err_i),
    .out_data    (out_data),
    .out_ovf     (out_ovf),
    .out_err     (out_err),
    .out_valid   (out_valid),
    .out_ready_i (out_ready_i),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .drop_cnt    (drop_cnt),
    .drop_flag   (drop_flag)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic res_entry_t model_entry(input logic [31:0] d, input bit ovf, input bit err);
    res_entry_t e;
    e.err = err;
    e.ovf = ovf;
    if (err)             e.data = '0;
    else if (SAT && ovf) e.data = '1;
    else                 e.data = d;
    return e;
  endfunction

  // Monitor: a head is consumed at the next edge whenever valid & ready and no rst/flush.
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready_i) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got data %0h expected no entry at %0t", out_data, $time);
      end else begin
        res_entry_t e;
        e = sb.pop_front();
        check("head_data", 64'(out_data), 64'(e.data));
        check("head_ovf", 64'(out_ovf), 64'(e.ovf));
        check("head_err", 64'(out_err), 64'(e.err));
      end
    end
  end

  // One cycle: check status against the model, drive inputs, advance the model, cross the edge.
  task automatic step(input bit push, input logic [31:0] d, input bit ovf, input bit err,
                      input bit rdy, input bit fl, input bit rs);
    bit pop_m, full_m;
    check("count", 64'(count), 64'(m_count));
    check("full", 64'(full), 64'(m_count == DEPTH));
    check("empty", 64'(empty), 64'(m_count == 0));
    check("out_valid", 64'(out_valid), 64'(m_count != 0));
    check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    check("drop_flag", 64'(drop_flag), 64'(m_flag));
    res_valid_i = push;
    res_i       = d;
    res_ovf_i   = ovf;
    res_err_i   = err;
    out_ready_i = rdy;
    flush       = fl;
    rst         = rs;
    if (rs || fl) begin
      m_count = 0;
      m_drop  = 0;
      m_flag  = 1'b0;
      sb.delete();
    end else begin
      pop_m  = rdy && (m_count > 0);
      full_m = (m_count == DEPTH);
      if (push) begin
        if (!full_m || pop_m) begin
          sb.push_back(model_entry(d, ovf, err));
          m_count++;
        end else begin
          m_flag = 1'b1;
          if (m_drop < 255) m_drop++;
        end
      end
      if (pop_m) m_count--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 32'h0, 1'b0, 1'b0, rdy, 1'b0, 1'b0);
  endtask

  task automatic push_v(input logic [31:0] d, input bit rdy);
    step(1'b1, d, 1'b0, 1'b0, rdy, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs();
    check("rst_out_data", 64'(out_data), 64'h0);
    check("rst_out_ovf", 64'(out_ovf), 64'h0);
    check("rst_out_err", 64'(out_err), 64'h0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; res_valid_i = 1'b0; res_i = '0;
    res_ovf_i = 1'b0; res_err_i = 1'b0; out_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_reset_outputs();

    // 1: single result through an empty buffer
    push_v(32'h0000_0123, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // 2: overfill with consumer stalled, then drain in order
    for (int i = 0; i < 5; i++) push_v(32'h11 + 32'(i), 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // 3: full with simultaneous push and pop
    for (int i = 0; i < 4; i++) push_v(32'h21 + 32'(i), 1'b0);
    push_v(32'hAA, 1'b1);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // 4: error forces zero data; overflow saturates only in the RESULT_SAT_EN build
    step(1'b1, 32'hDEAD, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // 5: flush with a coinciding push (drop counter is nonzero from case 2)
    for (int i = 0; i < 3; i++) push_v(32'h31 + 32'(i), 1'b0);
    step(1'b1, 32'h77, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b0);

    // 6: saturate the drop counter, then reset mid-drain
    for (int i = 0; i < 264; i++) push_v(32'h100 + 32'(i), 1'b0);
    idle(1'b1);
    idle(1'b1);
    step(1'b1, 32'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check_reset_outputs();
    idle(1'b1);

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 600; i++) begin
      bit fl, rs;
      fl = ($urandom_range(0, 49) == 0);
      rs = ($urandom_range(0, 199) == 0);
      step($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 3) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0, fl, rs);
    end
    for (int i = 0; i < 8; i++) idle(1'b1);
    check("scoreboard_drained", 64'(sb.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
